plru_repl_ctrl: RTL and testbench

- Per-set replacement controller for set-associative caches in the tile cache subsystem.
- Holds tree-PLRU state for every set.
- Arbitrates between the hit-path "touch" requester and the miss-path "victim" requester.
- Returns a victim way for allocation, honouring a per-request evictable mask, and updates the PLRU state after every touch and every allocation.

---
 rtl/plru_repl_pkg.sv | 18 +
 rtl/plru_tree_sel.sv | 80 ++++++++
 rtl/plru_repl_ctrl.sv | 171 +++++++++++++++++
 tb/tb_plru_repl_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/plru_repl_pkg.sv
// Shared types and helpers for the tree-PLRU replacement controller.
package plru_repl_pkg;

    typedef enum logic { OP_TOUCH = 1'b0, OP_VICTIM = 1'b1 } op_e;

    typedef enum logic { ST_INIT = 1'b0, ST_RUN = 1'b1 } fsm_e;

    // A binary tree over `ways` leaves has ways-1 internal nodes.
    function automatic int row_width(input int ways);
        return ways - 1;
    endfunction

    // Node (level, position) in the flattened tree row; the root is bit 0.
    function automatic int node_index(input int level, input int pos);
        return (1 << level) + pos - 1;
    endfunction

endpackage

// File: rtl/plru_tree_sel.sv
// Combinational tree-PLRU walker: picks a victim under an evictable mask and
// produces the updated row after touching either the given way or the victim.
module plru_tree_sel
    import plru_repl_pkg::*;
#(
    parameter int  WAYS     = 8,
    localparam int WAY_BITS = $clog2(WAYS),
    localparam int ROW_W    = row_width(WAYS)
) (
    input  logic [ROW_W-1:0]    row,
    input  logic [WAYS-1:0]     mask,
    input  logic [WAY_BITS-1:0] way,
    input  logic                use_victim,
    output logic [WAY_BITS-1:0] victim,
    output logic                fallback,
    output logic [ROW_W-1:0]    next_row
);

    logic [WAYS-1:0]     eff_mask;
    logic                any_lo;
    logic                any_hi;
    logic                go_hi;
    int                  pos;
    int                  span;
    int                  base;
    logic [WAY_BITS-1:0] upd_way;
    int                  upd_pos;

    // A node bit names the child to descend into: 0 = lower-indexed half.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        fallback = (mask == '0);
        eff_mask = fallback ? '1 : mask;
        pos      = 0;
        span     = 0;
        base     = 0;
        any_lo   = 1'b0;
        any_hi   = 1'b0;
        go_hi    = 1'b0;
        for (int lvl = 0; lvl < WAY_BITS; lvl++) begin
            span   = WAYS >> (lvl + 1);
            base   = pos * 2 * span;
            any_lo = 1'b0;
            any_hi = 1'b0;
            for (int i = 0; i < WAYS; i++) begin
                if (i >= base && i < base + span)
                    any_lo = any_lo | eff_mask[i];
                if (i >= base + span && i < base + 2 * span)
                    any_hi = any_hi | eff_mask[i];
            end
            go_hi = 1'b0;
            for (int n = 0; n < ROW_W; n++) begin
                if (n == node_index(lvl, pos))
                    go_hi = row[n];
            end
            // Steer around a subtree that holds no evictable way.
            if (go_hi && !any_hi)
                go_hi = 1'b0;
            else if (!go_hi && !any_lo)
                go_hi = 1'b1;
            pos = pos * 2 + int'(go_hi);
        end
        victim = pos[WAY_BITS-1:0];
    end

    // Each node on the path is flipped to point at the sibling of the used way.
    always_comb begin
        upd_way  = use_victim ? victim : way;
        next_row = row;
        upd_pos  = 0;
        for (int lvl = 0; lvl < WAY_BITS; lvl++) begin
            upd_pos = int'(upd_way) >> (WAY_BITS - lvl);
            for (int n = 0; n < ROW_W; n++) begin
                if (n == node_index(lvl, upd_pos))
                    next_row[n] = ~upd_way[WAY_BITS-1-lvl];
            end
        end
    end

endmodule

// File: rtl/plru_repl_ctrl.sv
// Per-set tree-PLRU replacement controller with touch/victim arbitration.
// Optional PLRU_REPL_STATS_EN adds saturating victim and fallback counters.
module plru_repl_ctrl
    import plru_repl_pkg::*;
#(
    parameter int  WAYS       = 8,
    parameter int  SETS       = 64,
    parameter int  STARVE_MAX = 4,
    localparam int WAY_BITS   = $clog2(WAYS),
    localparam int SET_BITS   = $clog2(SETS),
    localparam int ROW_W      = row_width(WAYS),
    localparam int CNT_W      = $clog2(STARVE_MAX + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                touch_valid,
    output logic                touch_ready,
    input  logic [SET_BITS-1:0] touch_set,
    input  logic [WAY_BITS-1:0] touch_way,
    input  logic                vic_req_valid,
    output logic                vic_req_ready,
    input  logic [SET_BITS-1:0] vic_req_set,
    input  logic [WAYS-1:0]     vic_req_evictable,
    output logic                vic_resp_valid,
    output logic [WAY_BITS-1:0] vic_resp_way,
    output logic                vic_resp_fallback,
`ifdef PLRU_REPL_STATS_EN
    output logic [31:0]         stat_vic_cnt,
    output logic [31:0]         stat_fallback_cnt,
`endif
    output logic                init_done
);

    fsm_e                state_q;
    fsm_e                state_d;
    logic [SET_BITS-1:0] init_cnt;
    logic [CNT_W-1:0]    starve_cnt;
    logic                run;
    logic                starved;
    logic                touch_grant;
    logic                vic_grant;

    logic [ROW_W-1:0]    mem [SETS];
    logic [SET_BITS-1:0] grant_set;
    logic [ROW_W-1:0]    rd_row;

    logic                s2_valid;
    op_e                 s2_op;
    logic [SET_BITS-1:0] s2_set;
    logic [WAY_BITS-1:0] s2_way;
    logic [WAYS-1:0]     s2_mask;
    logic [ROW_W-1:0]    s2_row;
    logic [ROW_W-1:0]    s2_next_row;
    logic [WAY_BITS-1:0] sel_victim;
    logic                sel_fallback;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset)
            state_q <= ST_INIT;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_INIT && init_cnt == SET_BITS'(SETS - 1))
            state_d = ST_RUN;
    end

    // Outputs are forced low during the reset cycle, even if the FSM is still in RUN.
    always_comb begin
        run           = (state_q == ST_RUN) && !reset;
        init_done     = run;
        starved       = vic_req_valid && (starve_cnt == CNT_W'(STARVE_MAX));
        touch_ready   = run && touch_valid && !starved;
        vic_req_ready = run && vic_req_valid && (!touch_valid || starved);
    end

    assign touch_grant = touch_ready;
    assign vic_grant   = vic_req_ready;

    always_ff @(posedge clk) begin
        if (reset)
            init_cnt <= '0;
        else if (state_q == ST_INIT)
            init_cnt <= init_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset || !vic_req_valid || vic_grant)
            starve_cnt <= '0;
        else if (touch_grant)
            starve_cnt <= starve_cnt + 1'b1;
    end

    // NOTE: the state array has no reset; the INIT sweep clears it one set per cycle instead.
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT)
            mem[init_cnt] <= '0;
        else if (s2_valid)
            mem[s2_set] <= s2_next_row;
    end

    // A same-set operation in S2 has not been written yet; take its result directly.
    always_comb begin
        grant_set = vic_grant ? vic_req_set : touch_set;
        if (s2_valid && s2_set == grant_set)
            rd_row = s2_next_row;
        else
            rd_row = mem[grant_set];
    end

    always_ff @(posedge clk) begin
        if (reset)
            s2_valid <= 1'b0;
        else
            s2_valid <= touch_grant || vic_grant;
    end

    always_ff @(posedge clk) begin
        if (touch_grant || vic_grant) begin
            s2_op   <= vic_grant ? OP_VICTIM : OP_TOUCH;
            s2_set  <= grant_set;
            s2_way  <= touch_way;
            s2_mask <= vic_req_evictable;
            s2_row  <= rd_row;
        end
    end

    plru_tree_sel #(
        .WAYS (WAYS)
    ) u_tree_sel (
        .row        (s2_row),
        .mask       (s2_mask),
        .way        (s2_way),
        .use_victim (s2_op == OP_VICTIM),
        .victim     (sel_victim),
        .fallback   (sel_fallback),
        .next_row   (s2_next_row)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            vic_resp_valid    <= 1'b0;
            vic_resp_way      <= '0;
            vic_resp_fallback <= 1'b0;
        end else begin
            vic_resp_valid <= s2_valid && (s2_op == OP_VICTIM);
            if (s2_valid && s2_op == OP_VICTIM) begin
                vic_resp_way      <= sel_victim;
                vic_resp_fallback <= sel_fallback;
            end
        end
    end

`ifdef PLRU_REPL_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_vic_cnt      <= '0;
            stat_fallback_cnt <= '0;
        end else begin
            if (vic_resp_valid && stat_vic_cnt != '1)
                stat_vic_cnt <= stat_vic_cnt + 32'd1;
            if (vic_resp_valid && vic_resp_fallback && stat_fallback_cnt != '1)
                stat_fallback_cnt <= stat_fallback_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_plru_repl_ctrl.sv
// Directed bench for plru_repl_ctrl: init timing, victim walk, masking,
// same-set forwarding, starvation limit and reset during an in-flight request.
module tb_plru_repl_ctrl;

    localparam int WAYS = 8;
    localparam int SETS = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       touch_valid = 1'b0;
    logic       touch_ready;
    logic [5:0] touch_set = '0;
    logic [2:0] touch_way = '0;
    logic       vic_req_valid = 1'b0;
    logic       vic_req_ready;
    logic [5:0] vic_req_set = '0;
    logic [7:0] vic_req_evictable = '0;
    logic       vic_resp_valid;
    logic [2:0] vic_resp_way;
    logic       vic_resp_fallback;
    logic       init_done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    plru_repl_ctrl #(
        .WAYS       (WAYS),
        .SETS       (SETS),
        .STARVE_MAX (4)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .touch_valid       (touch_valid),
        .touch_ready       (touch_ready),
        .touch_set         (touch_set),
        .touch_way         (touch_way),
        .vic_req_valid     (vic_req_valid),
        .vic_req_ready     (vic_req_ready),
        .vic_req_set       (vic_req_set),
        .vic_req_evictable (vic_req_evictable),
        .vic_resp_valid    (vic_resp_valid),
        .vic_resp_way      (vic_resp_way),
        .vic_resp_fallback (vic_resp_fallback),
        .init_done         (init_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles until init_done while both requesters push; nothing may be granted.
    task automatic wait_init(input string tag);
        int   n;
        logic seen;
        n    = 0;
        seen = 1'b0;
        touch_valid   = 1'b1;
        touch_set     = 6'd63;
        vic_req_valid = 1'b1;
        vic_req_set   = 6'd63;
        #1;
        while (!init_done && n < 200) begin
            if (touch_ready || vic_req_ready || vic_resp_valid)
                seen = 1'b1;
            tick();
            n++;
        end
        touch_valid   = 1'b0;
        vic_req_valid = 1'b0;
        check({tag, "_cycles"}, n, 64);
        check({tag, "_quiet"}, seen, 0);
    endtask

    task automatic victim(input string tag, input logic [5:0] set, input logic [7:0] mask,
                          input logic [2:0] exp_way, input logic exp_fb);
        vic_req_valid     = 1'b1;
        vic_req_set       = set;
        vic_req_evictable = mask;
        #1;
        check({tag, "_rdy"}, vic_req_ready, 1);
        tick();
        vic_req_valid = 1'b0;
        tick();
        check({tag, "_vld"}, vic_resp_valid, 1);
        check({tag, "_way"}, vic_resp_way, exp_way);
        check({tag, "_fb"}, vic_resp_fallback, exp_fb);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with both requesters active: every output must stay low.
        touch_valid   = 1'b1;
        vic_req_valid = 1'b1;
        repeat (3) tick();
        check("rst_init_done", init_done, 0);
        check("rst_touch_rdy", touch_ready, 0);
        check("rst_vic_rdy", vic_req_ready, 0);
        check("rst_resp", vic_resp_valid, 0);
        touch_valid   = 1'b0;
        vic_req_valid = 1'b0;
        reset = 1'b0;
        wait_init("init0");

        // Freshly cleared row: walk goes all the way to way 0.
        victim("first", 6'd5, 8'hFF, 3'd0, 1'b0);

        // Touch 0..7 back to back, then victim; then touch 0 and victim again.
        touch_valid = 1'b1;
        touch_set   = 6'd3;
        for (int w = 0; w < WAYS; w++) begin
            touch_way = 3'(w);
            #1;
            if (w == 0)
                check("touch_rdy", touch_ready, 1);
            tick();
        end
        touch_valid = 1'b0;
        victim("t07", 6'd3, 8'hFF, 3'd0, 1'b0);
        touch_valid = 1'b1;
        touch_way   = 3'd0;
        tick();
        touch_valid = 1'b0;
        victim("t0", 6'd3, 8'hFF, 3'd4, 1'b0);

        // Masking: only ways 4/5 allowed; then an empty mask falls back.
        victim("m30", 6'd9, 8'h30, 3'd4, 1'b0);
        victim("m00", 6'd9, 8'h00, 3'd0, 1'b1);

        // Two victims on the same set in consecutive cycles.
        vic_req_valid     = 1'b1;
        vic_req_set       = 6'd2;
        vic_req_evictable = 8'hFF;
        tick();
        tick();
        vic_req_valid = 1'b0;
        check("b2b0_vld", vic_resp_valid, 1);
        check("b2b0_way", vic_resp_way, 0);
        tick();
        check("b2b1_vld", vic_resp_valid, 1);
        check("b2b1_way", vic_resp_way, 4);
        tick();
        check("b2b_pulse", vic_resp_valid, 0);

        // Continuous touches starve the victim for exactly four grants.
        touch_valid       = 1'b1;
        touch_set         = 6'd10;
        touch_way         = 3'd1;
        vic_req_valid     = 1'b1;
        vic_req_set       = 6'd11;
        vic_req_evictable = 8'hFF;
        for (int c = 1; c <= 4; c++) begin
            #1;
            check($sformatf("starve%0d_trdy", c), touch_ready, 1);
            check($sformatf("starve%0d_vrdy", c), vic_req_ready, 0);
            tick();
        end
        #1;
        check("starve5_trdy", touch_ready, 0);
        check("starve5_vrdy", vic_req_ready, 1);
        tick();
        check("starve6_trdy", touch_ready, 1);
        check("starve6_vrdy", vic_req_ready, 0);
        touch_valid   = 1'b0;
        vic_req_valid = 1'b0;
        tick();
        check("starve_resp_vld", vic_resp_valid, 1);
        check("starve_resp_way", vic_resp_way, 0);

        // Reset right after a victim grant: the response must be dropped.
        vic_req_valid = 1'b1;
        vic_req_set   = 6'd20;
        #1;
        check("pre_rst_vrdy", vic_req_ready, 1);
        tick();
        reset       = 1'b1;
        touch_valid = 1'b1;
        #1;
        check("mid_rst_trdy", touch_ready, 0);
        check("mid_rst_vrdy", vic_req_ready, 0);
        check("mid_rst_done", init_done, 0);
        tick();
        check("rst_drop_resp", vic_resp_valid, 0);
        touch_valid   = 1'b0;
        vic_req_valid = 1'b0;
        reset = 1'b0;
        wait_init("init1");

        // Set 3 was disturbed before reset; INIT must have cleared it.
        victim("reinit", 6'd3, 8'hFF, 3'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
